// File: rtl/tour_pkg.sv
// Shared state type, one-hot move codes and move-to-offset tables
// for the knight's-tour solver.
package tour_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_DONE,
      ST_FAIL
   } tour_state_e;

   localparam logic [7:0] MV_0 = 8'h01;
   localparam logic [7:0] MV_1 = 8'h02;
   localparam logic [7:0] MV_2 = 8'h04;
   localparam logic [7:0] MV_3 = 8'h08;
   localparam logic [7:0] MV_4 = 8'h10;
   localparam logic [7:0] MV_5 = 8'h20;
   localparam logic [7:0] MV_6 = 8'h40;
   localparam logic [7:0] MV_7 = 8'h80;

   // Non-one-hot codes map to a zero offset.
   function automatic logic signed [3:0] off_x(input logic [7:0] mv);
      logic signed [3:0] d;
      case (mv)
         MV_0:    d = 4'sd1;
         MV_1:    d = -4'sd1;
         MV_2:    d = -4'sd2;
         MV_3:    d = -4'sd2;
         MV_4:    d = -4'sd1;
         MV_5:    d = 4'sd1;
         MV_6:    d = 4'sd2;
         MV_7:    d = 4'sd2;
         default: d = 4'sd0;
      endcase
      return d;
   endfunction

   function automatic logic signed [3:0] off_y(input logic [7:0] mv);
      logic signed [3:0] d;
      case (mv)
         MV_0:    d = 4'sd2;
         MV_1:    d = 4'sd2;
         MV_2:    d = 4'sd1;
         MV_3:    d = -4'sd1;
         MV_4:    d = -4'sd2;
         MV_5:    d = -4'sd2;
         MV_6:    d = -4'sd1;
         MV_7:    d = 4'sd1;
         default: d = 4'sd0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/knight_move_chk.sv
// Combinational legality mask: bit k is set when knight move k from (xx, yy)
// lands on the board and on an unvisited square.
module knight_move_chk
   import tour_pkg::*;
#(
   parameter int N = 5
) (
   input  logic [$clog2(N)-1:0] xx,
   input  logic [$clog2(N)-1:0] yy,
   input  logic [N*N-1:0]       visited,
   output logic [7:0]           legal_mask
);

   localparam int CW = $clog2(N);
   localparam int SW = CW + 2;
   localparam int MW = $clog2(N*N);

   for (genvar gi = 0; gi < 8; gi++) begin : g_mv
      logic signed [SW-1:0] tx;
      logic signed [SW-1:0] ty;
      logic                 on_board;
      logic [MW-1:0]        sq;

      // Two guard bits keep negative and past-the-edge targets distinct from real squares.
      assign tx = $signed({2'b00, xx}) + SW'(off_x(8'(1 << gi)));
      assign ty = $signed({2'b00, yy}) + SW'(off_y(8'(1 << gi)));

      assign on_board = !tx[SW-1] && (tx < SW'(N)) && !ty[SW-1] && (ty < SW'(N));
      assign sq       = on_board ? (MW'(ty[CW-1:0]) * MW'(N) + MW'(tx[CW-1:0])) : '0;

      assign legal_mask[gi] = on_board & ~visited[sq];
   end

endmodule

// File: rtl/tour_solver_n.sv
// Depth-first knight's-tour search on an N x N board with host read-back of
// the move list. Define TOUR_TIMEOUT_EN to bound the search to MAX_CYCLES.
module tour_solver_n
   import tour_pkg::*;
#(
   parameter int N          = 5,
   parameter int CW         = $clog2(N),
   parameter int MW         = $clog2(N*N),
   parameter int MAX_CYCLES = 2**24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CW-1:0] x_start,
   input  logic [CW-1:0] y_start,
   input  logic          go,
   input  logic          abort,
   input  logic [MW-1:0] indx,
   output logic [7:0]    move,
   output logic          busy,
   output logic          done,
   output logic          fail
);

   localparam int SQ = N * N;
   localparam int AW = $clog2(SQ - 1);

   tour_state_e   state;
   logic [CW-1:0] xx, yy;
   logic [SQ-1:0] visited;
   logic [7:0]    last_move [SQ-1];
   logic [7:0]    move_try;
   logic [MW:0]   move_num;

   logic [7:0]    legal_mask;
   logic [7:0]    prev_move;
   logic [AW-1:0] cur_idx, prev_idx;
   logic [MW-1:0] cur_sq, step_sq, start_sq;
   logic [CW-1:0] step_x, step_y, back_x, back_y;
   logic          start_bad;
   logic          time_up;

   knight_move_chk #(.N(N)) u_chk (
      .xx         (xx),
      .yy         (yy),
      .visited    (visited),
      .legal_mask (legal_mask)
   );

   assign cur_idx   = AW'(move_num - (MW+1)'(1));
   assign prev_idx  = AW'(move_num - (MW+1)'(2));
   assign prev_move = last_move[prev_idx];

   assign cur_sq   = MW'(yy) * MW'(N) + MW'(xx);
   assign step_x   = xx + CW'(off_x(move_try));
   assign step_y   = yy + CW'(off_y(move_try));
   assign step_sq  = MW'(step_y) * MW'(N) + MW'(step_x);
   assign back_x   = xx - CW'(off_x(prev_move));
   assign back_y   = yy - CW'(off_y(prev_move));
   assign start_sq = MW'(y_start) * MW'(N) + MW'(x_start);

   assign start_bad = (int'(x_start) >= N) || (int'(y_start) >= N);

   assign busy = (state == ST_SEARCH);
   assign move = (int'(indx) < SQ - 1) ? last_move[indx[AW-1:0]] : 8'h00;

`ifdef TOUR_TIMEOUT_EN
   logic [31:0] cyc_cnt;

   // The MAX_CYCLES-th SEARCH cycle is the last one.
   assign time_up = (cyc_cnt == 32'(MAX_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cyc_cnt <= '0;
      end else if (state == ST_IDLE && go) begin
         cyc_cnt <= '0;
      end else if (state == ST_SEARCH) begin
         cyc_cnt <= cyc_cnt + 32'd1;
      end
   end
`else
   assign time_up = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         xx       <= '0;
         yy       <= '0;
         visited  <= '0;
         move_try <= MV_0;
         move_num <= (MW+1)'(1);
         done     <= 1'b0;
         fail     <= 1'b0;
         for (int i = 0; i < SQ - 1; i++) begin
            last_move[i] <= '0;
         end
      end else begin
         done <= (state == ST_DONE);
         fail <= (state == ST_FAIL);
         case (state)
            ST_IDLE: begin
               if (go) begin
                  if (start_bad) begin
                     state <= ST_FAIL;
                  end else begin
                     xx       <= x_start;
                     yy       <= y_start;
                     visited  <= {{(SQ-1){1'b0}}, 1'b1} << start_sq;
                     move_try <= MV_0;
                     move_num <= (MW+1)'(1);
                     state    <= ST_SEARCH;
                     for (int i = 0; i < SQ - 1; i++) begin
                        last_move[i] <= '0;
                     end
                  end
               end
            end
            ST_SEARCH: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (time_up) begin
                  state <= ST_FAIL;
               end else if (move_num == (MW+1)'(SQ)) begin
                  state <= ST_DONE;
               end else if (move_try == '0) begin
                  if (move_num == (MW+1)'(1)) begin
                     state <= ST_FAIL;
                  end else begin
                     // Undo the move that led here and resume with the next candidate.
                     visited[cur_sq] <= 1'b0;
                     xx              <= back_x;
                     yy              <= back_y;
                     move_try        <= prev_move << 1;
                     move_num        <= move_num - (MW+1)'(1);
                  end
               end else if ((legal_mask & move_try) != '0) begin
                  last_move[cur_idx] <= move_try;
                  xx                 <= step_x;
                  yy                 <= step_y;
                  visited[step_sq]   <= 1'b1;
                  move_num           <= move_num + (MW+1)'(1);
                  move_try           <= MV_0;
               end else begin
                  move_try <= move_try << 1;
               end
            end
            ST_DONE, ST_FAIL: state <= ST_IDLE;
            default:          state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tour_solver_n.sv
// Self-checking bench for tour_solver_n on 5x5, 4x4 and 3x3 boards (plus a
// short-budget 5x5 instance when TOUR_TIMEOUT_EN is defined).
module tb_tour_solver_n;

`ifdef TOUR_TIMEOUT_EN
   localparam int ND = 4;
`else
   localparam int ND = 3;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic [ND-1:0]       go, abort, busy, done, fail;
   logic [ND-1:0][2:0]  xs, ys;
   logic [ND-1:0][5:0]  ix;
   logic [ND-1:0][7:0]  mv;
   logic [ND-1:0]       model_search;
   logic [ND-1:0]       pulse_prev = '0;

   int ncmp = 0;
   int nerr = 0;

   tour_solver_n #(.N(5)) u_n5 (
      .clk(clk), .rst_n(rst_n), .x_start(xs[0]), .y_start(ys[0]), .go(go[0]),
      .abort(abort[0]), .indx(ix[0][4:0]), .move(mv[0]), .busy(busy[0]),
      .done(done[0]), .fail(fail[0])
   );

   tour_solver_n #(.N(4)) u_n4 (
      .clk(clk), .rst_n(rst_n), .x_start(xs[1][1:0]), .y_start(ys[1][1:0]), .go(go[1]),
      .abort(abort[1]), .indx(ix[1][3:0]), .move(mv[1]), .busy(busy[1]),
      .done(done[1]), .fail(fail[1])
   );

   tour_solver_n #(.N(3)) u_n3 (
      .clk(clk), .rst_n(rst_n), .x_start(xs[2][1:0]), .y_start(ys[2][1:0]), .go(go[2]),
      .abort(abort[2]), .indx(ix[2][3:0]), .move(mv[2]), .busy(busy[2]),
      .done(done[2]), .fail(fail[2])
   );

`ifdef TOUR_TIMEOUT_EN
   tour_solver_n #(.N(5), .MAX_CYCLES(50)) u_n5_to (
      .clk(clk), .rst_n(rst_n), .x_start(xs[3]), .y_start(ys[3]), .go(go[3]),
      .abort(abort[3]), .indx(ix[3][4:0]), .move(mv[3]), .busy(busy[3]),
      .done(done[3]), .fail(fail[3])
   );
`endif

   function automatic int nof(input int d);
      return (d == 1) ? 4 : (d == 2) ? 3 : 5;
   endfunction

   // Size of the indx address space of each instance.
   function automatic int ispace(input int d);
      return (d == 1 || d == 2) ? 16 : 32;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      ncmp++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Per-cycle protocol checks against the bench's view of each solver.
   always begin
      @(negedge clk);
      #1;
      if (rst_n) begin
         for (int d = 0; d < ND; d++) begin
            if (done[d] || fail[d]) begin
               chk("done_fail_exclusive", int'(done[d] & fail[d]), 0);
               chk("busy_at_pulse", int'(busy[d]), 0);
               chk("pulse_width", int'(pulse_prev[d]), 0);
            end
            if (!model_search[d]) chk("busy_when_idle", int'(busy[d]), 0);
            if (int'(ix[d]) >= nof(d) * nof(d) - 1 && int'(ix[d]) < ispace(d))
               chk("move_past_end", int'(mv[d]), 0);
            pulse_prev[d] = done[d] | fail[d];
         end
      end
   end

   // res: 1 = done, 2 = fail, 0 = budget expired. lat counts clock edges from the go edge.
   task automatic run(input int d, input int x, input int y, input int budget, input bit noise,
                      output int res, output int bcyc, output int lat);
      xs[d] = 3'(x);
      ys[d] = 3'(y);
      go[d] = 1'b1;
      @(negedge clk);
      go[d] = 1'b0;
      model_search[d] = (x < nof(d)) && (y < nof(d));
      res  = 0;
      bcyc = 0;
      lat  = 1;
      while (lat < budget) begin
         if (busy[d]) bcyc++;
         if (done[d]) begin res = 1; break; end
         if (fail[d]) begin res = 2; break; end
         if (noise && busy[d] && $urandom_range(0, 7) == 0) begin
            go[d] = 1'b1;
            xs[d] = 3'($urandom_range(0, 7));
            ys[d] = 3'($urandom_range(0, 7));
         end else begin
            go[d] = 1'b0;
         end
         ix[d] = 6'($urandom_range(0, ispace(d) - 1));
         @(negedge clk);
         lat++;
      end
      go[d] = 1'b0;
      model_search[d] = 1'b0;
      if (res == 0) begin
         ncmp++;
         nerr++;
         $display("FAIL search_budget: N=%0d start (%0d,%0d) no done/fail within %0d cycles",
                  nof(d), x, y, budget);
      end
      $display("run N=%0d start (%0d,%0d): result=%0d busy_cycles=%0d latency=%0d",
               nof(d), x, y, res, bcyc, lat);
   endtask

   // Replay the stored moves from the start square and count distinct on-board squares.
   task automatic check_tour(input int d, input int x, input int y);
      int dxt[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
      int dyt[8] = '{2, 2, 1, -1, -2, -2, -1, 1};
      bit seen[64];
      int n, cx, cy, cnt, b;
      n  = nof(d);
      cx = x;
      cy = y;
      cnt = 1;
      foreach (seen[i]) seen[i] = 1'b0;
      seen[cy * n + cx] = 1'b1;
      for (int i = 0; i < n * n - 1; i++) begin
         @(negedge clk);
         ix[d] = 6'(i);
         #2;
         if ($countones(mv[d]) != 1) break;
         b = 0;
         for (int k = 0; k < 8; k++) if (mv[d][k]) b = k;
         cx += dxt[b];
         cy += dyt[b];
         if (cx < 0 || cx >= n || cy < 0 || cy >= n) break;
         if (seen[cy * n + cx]) break;
         seen[cy * n + cx] = 1'b1;
         cnt++;
      end
      chk("tour_squares_covered", cnt, n * n);
      @(negedge clk);
      ix[d] = 6'(n * n - 1);
      #2;
      chk("move_at_last_index", int'(mv[d]), 0);
      $display("tour replay N=%0d start (%0d,%0d): %0d squares", n, x, y, cnt);
   endtask

   task automatic abort_after(input int d, input int x, input int y, input int k);
      int seen_pulse;
      xs[d] = 3'(x);
      ys[d] = 3'(y);
      go[d] = 1'b1;
      @(negedge clk);
      go[d] = 1'b0;
      model_search[d] = 1'b1;
      repeat (k - 1) @(negedge clk);
      chk("busy_before_abort", int'(busy[d]), 1);
      abort[d] = 1'b1;
      @(negedge clk);
      abort[d] = 1'b0;
      model_search[d] = 1'b0;
      #2;
      chk("idle_after_abort", int'(busy[d]), 0);
      seen_pulse = 0;
      repeat (4) begin
         @(negedge clk);
         #2;
         if (done[d] || fail[d]) seen_pulse = 1;
      end
      chk("no_pulse_after_abort", seen_pulse, 0);
      $display("abort N=%0d start (%0d,%0d) after %0d search cycles", nof(d), x, y, k);
   endtask

   initial begin
      int res, bcyc, lat, x, y, k;
      rst_n = 1'b0;
      go = '0;
      abort = '0;
      xs = '0;
      ys = '0;
      ix = '0;
      model_search = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #2;
      for (int d = 0; d < ND; d++) begin
         chk("reset_busy", int'(busy[d]), 0);
         chk("reset_pulses", int'(done[d] | fail[d]), 0);
         chk("reset_move0", int'(mv[d]), 0);
      end

      // 3x3 centre: every move leaves the board, so 8 shifts plus the exhaust cycle.
      run(2, 1, 1, 1000, 1'b0, res, bcyc, lat);
      chk("n3_centre_result", res, 2);
      chk("n3_centre_busy_cycles", bcyc, 9);
      chk("n3_centre_latency", lat, 11);

      run(2, 0, 0, 100000, 1'b1, res, bcyc, lat);
      chk("n3_corner_result", res, 2);

      for (int t = 0; t < 3; t++) begin
         x = $urandom_range(5, 7);
         y = $urandom_range(0, 7);
         if (t == 1) begin
            k = x;
            x = y;
            y = k;
         end
         run(0, x, y, 100, 1'b0, res, bcyc, lat);
         chk("range_result", res, 2);
         chk("range_latency", lat, 2);
         chk("range_busy_cycles", bcyc, 0);
      end

      run(0, 2, 2, 4000000, 1'b1, res, bcyc, lat);
      chk("n5_centre_result", res, 1);
      check_tour(0, 2, 2);

      abort_after(0, 2, 2, 100);
      for (int t = 0; t < 3; t++) begin
         abort_after(0, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(5, 24));
      end

      run(0, 0, 0, 4000000, 1'b1, res, bcyc, lat);
      chk("n5_corner_result", res, 1);
      check_tour(0, 0, 0);

      run(1, 0, 0, 2000000, 1'b1, res, bcyc, lat);
      chk("n4_corner_result", res, 2);

      // Reset in the middle of a search.
      xs[0] = 3'd2;
      ys[0] = 3'd2;
      go[0] = 1'b1;
      @(negedge clk);
      go[0] = 1'b0;
      model_search[0] = 1'b1;
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_search = '0;
      #2;
      chk("reset_mid_busy", int'(busy[0]), 0);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         ix[0] = 6'(i);
         #2;
         chk("reset_mid_move", int'(mv[0]), 0);
      end
      $display("reset mid-search N=5 checked");

`ifdef TOUR_TIMEOUT_EN
      run(3, 0, 1, 1000, 1'b1, res, bcyc, lat);
      chk("timeout_result", res, 2);
      chk("timeout_busy_cycles", bcyc, 50);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
